// File: rtl/axi3_hp_slave.sv
// AXI3 responder with on-chip word memory; one outstanding burst per direction.
// Optional: define AXI3_SLV_STALL_EN to gate wready/arready with an LFSR for backpressure.
module axi3_hp_slave #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ID_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  // write address
  input  logic [31:0]     AXI_awaddr,
  input  logic [1:0]      AXI_awburst,
  input  logic [ID_W-1:0] AXI_awid,
  input  logic [3:0]      AXI_awlen,
  input  logic [2:0]      AXI_awsize,
  input  logic            AXI_awvalid,
  output logic            AXI_awready,
  // write data
  input  logic [31:0]     AXI_wdata,
  input  logic [ID_W-1:0] AXI_wid,
  input  logic [3:0]      AXI_wstrb,
  input  logic            AXI_wlast,
  input  logic            AXI_wvalid,
  output logic            AXI_wready,
  // write response
  output logic [ID_W-1:0] AXI_bid,
  output logic [1:0]      AXI_bresp,
  output logic            AXI_bvalid,
  input  logic            AXI_bready,
  // read address
  input  logic [31:0]     AXI_araddr,
  input  logic [1:0]      AXI_arburst,
  input  logic [ID_W-1:0] AXI_arid,
  input  logic [3:0]      AXI_arlen,
  input  logic [2:0]      AXI_arsize,
  input  logic            AXI_arvalid,
  output logic            AXI_arready,
  // read data
  output logic [31:0]     AXI_rdata,
  output logic [ID_W-1:0] AXI_rid,
  output logic [1:0]      AXI_rresp,
  output logic            AXI_rlast,
  output logic            AXI_rvalid,
  input  logic            AXI_rready,
  // burst completion counters
  output logic [31:0]     wr_bursts,
  output logic [31:0]     rd_bursts
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // Word address of the next beat: FIXED holds, WRAP stays inside a (len+1)-word aligned block,
  // INCR and the reserved encoding step one word modulo the memory depth.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0]        burst,
                                                  input logic [3:0]        len);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    mask = ADDR_W'(len);
    inc  = addr + 1'b1;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  logic [31:0] mem [Depth];

  logic stall_ok;
  logic init_q;

  // write channel state
  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_addr_q;
  logic [3:0]        w_len_q;
  logic [3:0]        w_beat_q;
  logic [1:0]        w_burst_q;
  logic              w_err_q;
  logic [ID_W-1:0]   w_id_q;
  logic [31:0]       wr_bursts_q;
  logic              aw_ready_s, w_ready_s, b_valid_s;
  logic              aw_hs, w_hs, b_hs;

  // read channel state
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q;
  logic [3:0]        r_len_q;
  logic [3:0]        r_beat_q;
  logic [1:0]        r_burst_q;
  logic [31:0]       rdata_q;
  logic [ID_W-1:0]   rid_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic [31:0]       rd_bursts_q;
  logic              ar_ready_s, r_valid_s;
  logic              ar_hs, r_hs;
  logic [ADDR_W-1:0] ar_word;
  logic [ADDR_W-1:0] r_next;

`ifdef AXI3_SLV_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall_ok = lfsr_q[0];
`else
  assign stall_ok = 1'b1;
`endif

  // Holds both address channels closed until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_s = 1'b0;
    w_ready_s  = 1'b0;
    b_valid_s  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        aw_ready_s = init_q;
        if (AXI_awvalid && init_q) w_state_d = WData;
      end
      WData: begin
        w_ready_s = stall_ok;
        if (AXI_wvalid && stall_ok && (w_beat_q == w_len_q)) w_state_d = WResp;
      end
      WResp: begin
        b_valid_s = 1'b1;
        if (AXI_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign aw_hs = AXI_awvalid & aw_ready_s;
  assign w_hs  = AXI_wvalid & w_ready_s;
  assign b_hs  = AXI_bready & b_valid_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= WIdle;
      w_addr_q    <= '0;
      w_len_q     <= '0;
      w_beat_q    <= '0;
      w_burst_q   <= '0;
      w_err_q     <= 1'b0;
      w_id_q      <= '0;
      wr_bursts_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_addr_q  <= AXI_awaddr[ADDR_W+1:2];
        w_len_q   <= AXI_awlen;
        w_beat_q  <= '0;
        w_burst_q <= AXI_awburst;
        w_id_q    <= AXI_awid;
        w_err_q   <= (AXI_awsize != 3'b010) || (AXI_awburst == 2'b11);
      end
      if (w_hs) begin
        w_addr_q <= next_addr(w_addr_q, w_burst_q, w_len_q);
        w_beat_q <= w_beat_q + 4'd1;
        // wlast is only checked, never trusted: the beat count alone closes the burst
        if (AXI_wlast != (w_beat_q == w_len_q)) w_err_q <= 1'b1;
      end
      if (b_hs) wr_bursts_q <= wr_bursts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (AXI_wstrb[i]) mem[w_addr_q][8*i +: 8] <= AXI_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_s = 1'b0;
    r_valid_s  = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        ar_ready_s = init_q & stall_ok;
        if (AXI_arvalid && init_q && stall_ok) r_state_d = RData;
      end
      RData: begin
        r_valid_s = 1'b1;
        if (AXI_rready && rlast_q) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign ar_hs   = AXI_arvalid & ar_ready_s;
  assign r_hs    = AXI_rready & r_valid_s;
  assign ar_word = AXI_araddr[ADDR_W+1:2];
  assign r_next  = next_addr(r_addr_q, r_burst_q, r_len_q);

  // rdata is fetched one beat ahead so every accepted beat is followed by the next one at once;
  // a same-cycle write to that word lands after this fetch, so the old value is returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q   <= RIdle;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_beat_q    <= '0;
      r_burst_q   <= '0;
      rdata_q     <= '0;
      rid_q       <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      rd_bursts_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_addr_q  <= ar_word;
        r_len_q   <= AXI_arlen;
        r_beat_q  <= '0;
        r_burst_q <= AXI_arburst;
        rdata_q   <= mem[ar_word];
        rid_q     <= AXI_arid;
        rlast_q   <= (AXI_arlen == 4'd0);
        rresp_q   <= ((AXI_arsize != 3'b010) || (AXI_arburst == 2'b11)) ? 2'b10 : 2'b00;
      end
      if (r_hs && !rlast_q) begin
        r_addr_q <= r_next;
        r_beat_q <= r_beat_q + 4'd1;
        rdata_q  <= mem[r_next];
        rlast_q  <= ((r_beat_q + 4'd1) == r_len_q);
      end
      if (r_hs && rlast_q) rd_bursts_q <= rd_bursts_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign AXI_awready = aw_ready_s;
  assign AXI_wready  = w_ready_s;
  assign AXI_bvalid  = b_valid_s;
  assign AXI_bid     = w_id_q;
  assign AXI_bresp   = (b_valid_s && w_err_q) ? 2'b10 : 2'b00;
  assign AXI_arready = ar_ready_s;
  assign AXI_rvalid  = r_valid_s;
  assign AXI_rdata   = rdata_q;
  assign AXI_rid     = rid_q;
  assign AXI_rresp   = rresp_q;
  assign AXI_rlast   = rlast_q;
  assign wr_bursts   = wr_bursts_q;
  assign rd_bursts   = rd_bursts_q;

  logic unused_inputs;
  assign unused_inputs = ^{AXI_wid, AXI_awaddr[31:ADDR_W+2], AXI_awaddr[1:0],
                           AXI_araddr[31:ADDR_W+2], AXI_araddr[1:0]};

endmodule

// File: tb/tb_axi3_hp_slave.sv
// Scoreboard bench for axi3_hp_slave: directed cases plus random bursts checked against a
// word-array reference model; a monitor pops expected B/R responses as the DUT presents them.
`timescale 1ns/1ps
module tb_axi3_hp_slave;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [5:0]  id;
  } r_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] AXI_awaddr = '0;
  logic [1:0]  AXI_awburst = '0;
  logic [5:0]  AXI_awid = '0;
  logic [3:0]  AXI_awlen = '0;
  logic [2:0]  AXI_awsize = '0;
  logic        AXI_awvalid = 1'b0;
  logic        AXI_awready;
  logic [31:0] AXI_wdata = '0;
  logic [5:0]  AXI_wid = '0;
  logic [3:0]  AXI_wstrb = '0;
  logic        AXI_wlast = 1'b0;
  logic        AXI_wvalid = 1'b0;
  logic        AXI_wready;
  logic [5:0]  AXI_bid;
  logic [1:0]  AXI_bresp;
  logic        AXI_bvalid;
  logic        AXI_bready = 1'b0;
  logic [31:0] AXI_araddr = '0;
  logic [1:0]  AXI_arburst = '0;
  logic [5:0]  AXI_arid = '0;
  logic [3:0]  AXI_arlen = '0;
  logic [2:0]  AXI_arsize = '0;
  logic        AXI_arvalid = 1'b0;
  logic        AXI_arready;
  logic [31:0] AXI_rdata;
  logic [5:0]  AXI_rid;
  logic [1:0]  AXI_rresp;
  logic        AXI_rlast;
  logic        AXI_rvalid;
  logic        AXI_rready = 1'b0;
  logic [31:0] wr_bursts;
  logic [31:0] rd_bursts;

  axi3_hp_slave #(.ADDR_W(10), .ID_W(6)) dut (
    .clk(clk), .rst(rst),
    .AXI_awaddr(AXI_awaddr), .AXI_awburst(AXI_awburst), .AXI_awid(AXI_awid),
    .AXI_awlen(AXI_awlen), .AXI_awsize(AXI_awsize), .AXI_awvalid(AXI_awvalid),
    .AXI_awready(AXI_awready),
    .AXI_wdata(AXI_wdata), .AXI_wid(AXI_wid), .AXI_wstrb(AXI_wstrb), .AXI_wlast(AXI_wlast),
    .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
    .AXI_bid(AXI_bid), .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
    .AXI_araddr(AXI_araddr), .AXI_arburst(AXI_arburst), .AXI_arid(AXI_arid),
    .AXI_arlen(AXI_arlen), .AXI_arsize(AXI_arsize), .AXI_arvalid(AXI_arvalid),
    .AXI_arready(AXI_arready),
    .AXI_rdata(AXI_rdata), .AXI_rid(AXI_rid), .AXI_rresp(AXI_rresp), .AXI_rlast(AXI_rlast),
    .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready),
    .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  bit          rr_manual = 1'b0;
  logic [31:0] mdl [1024];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  b_exp_t      exp_b [$];
  r_exp_t      exp_r [$];
  int          hs_cyc [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Word index of beat i, from the burst rules stated in words.
  function automatic int word_at(input logic [31:0] a, input int len, input logic [1:0] b,
                                 input int i);
    int w, n, base;
    w = int'((a >> 2) & 32'h3FF);
    n = len + 1;
    case (b)
      2'b00:   return w;
      2'b10: begin
        base = w - (w % n);
        return base + ((w - base + i) % n);
      end
      default: return (w + i) % 1024;
    endcase
  endfunction

  // Monitor: compares each presented B/R response against the head of its queue.
  initial begin
    r_exp_t re;
    b_exp_t be;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (AXI_bvalid && AXI_bready) begin
          if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got bid %0h bresp %0h with none expected", AXI_bid,
                     AXI_bresp);
          end else begin
            be = exp_b.pop_front();
            check("b_id_resp", 64'({AXI_bid, AXI_bresp}), 64'({be.id, be.resp}));
          end
        end
        if (AXI_rvalid) begin
          if (exp_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected: got rdata %0h with no beat expected", AXI_rdata);
          end else if (AXI_rready) begin
            re = exp_r.pop_front();
            hs_cyc.push_back(cyc);
            check("r_beat", 64'({AXI_rid, AXI_rresp, AXI_rlast, AXI_rdata}),
                  64'({re.id, re.resp, re.last, re.data}));
          end else begin
            re = exp_r[0];
            check("r_stall_hold", 64'({AXI_rid, AXI_rresp, AXI_rlast, AXI_rdata}),
                  64'({re.id, re.resp, re.last, re.data}));
          end
        end
      end
      cyc++;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    AXI_bready = ($urandom_range(0, 2) != 0);
    if (!rr_manual) AXI_rready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #2_000_000;
    abort_timeout("watchdog");
  end

  task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                         input logic [2:0] s, input logic [5:0] id);
    int n;
    AXI_awaddr = a; AXI_awlen = l; AXI_awburst = b; AXI_awsize = s; AXI_awid = id;
    AXI_awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AXI_awready && n < 200);
    if (!AXI_awready) abort_timeout("aw_ready");
    @(posedge clk); #1;
    AXI_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic last,
                        input logic [5:0] id);
    int n;
    while ($urandom_range(0, 3) == 0) begin
      AXI_wvalid = 1'b0;
      @(posedge clk); #1;
    end
    AXI_wvalid = 1'b1; AXI_wdata = d; AXI_wstrb = st; AXI_wlast = last; AXI_wid = id;
    n = 0;
    do begin @(negedge clk); n++; end while (!AXI_wready && n < 200);
    if (!AXI_wready) abort_timeout("w_ready");
    @(posedge clk); #1;
    AXI_wvalid = 1'b0; AXI_wlast = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                         input logic [2:0] s, input logic [5:0] id);
    int n;
    AXI_araddr = a; AXI_arlen = l; AXI_arburst = b; AXI_arsize = s; AXI_arid = id;
    AXI_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AXI_arready && n < 200);
    if (!AXI_arready) abort_timeout("ar_ready");
    @(posedge clk); #1;
    AXI_arvalid = 1'b0;
  endtask

  // early < 0: wlast on the final beat; otherwise wlast only on beat `early`.
  task automatic do_write(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                          input logic [2:0] s, input logic [5:0] id, input int early);
    bit err;
    bit lastv [16];
    int w, n;
    err = (s != 3'b010) || (b == 2'b11);
    for (int i = 0; i <= int'(l); i++) begin
      lastv[i] = (early >= 0) ? (i == early) : (i == int'(l));
      w = word_at(a, int'(l), b, i);
      if (!err) begin
        for (int k = 0; k < 4; k++) if (ws[i][k]) mdl[w][8*k +: 8] = wd[i][8*k +: 8];
      end
      if (lastv[i] != (i == int'(l))) err = 1'b1;
    end
    exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    wr_cnt++;
    send_aw(a, l, b, s, id);
    for (int i = 0; i <= int'(l); i++) send_w(wd[i], ws[i], lastv[i], id);
    n = 0;
    while (exp_b.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_b.size() != 0) abort_timeout("b_resp");
    @(posedge clk); #1;
  endtask

  task automatic push_read(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                           input logic [2:0] s, input logic [5:0] id);
    logic [1:0] resp;
    resp = ((s != 3'b010) || (b == 2'b11)) ? 2'b10 : 2'b00;
    for (int i = 0; i <= int'(l); i++) begin
      exp_r.push_back('{data: mdl[word_at(a, int'(l), b, i)], last: (i == int'(l)), resp: resp,
                        id: id});
    end
    rd_cnt++;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                         input logic [2:0] s, input logic [5:0] id);
    int n;
    push_read(a, l, b, s, id);
    send_ar(a, l, b, s, id);
    n = 0;
    while (exp_r.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (exp_r.size() != 0) abort_timeout("r_data");
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_wr_bursts"}, 64'(wr_bursts), 64'(wr_cnt));
    check({tag, "_rd_bursts"}, 64'(rd_bursts), 64'(rd_cnt));
  endtask

  initial begin
    int n;
    logic [3:0]  rlen;
    logic [1:0]  rb;
    logic [2:0]  rs;
    int          early;
    logic [31:0] a;
    bit          pat [4];

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_valid", 64'({AXI_awready, AXI_wready, AXI_bvalid, AXI_arready, AXI_rvalid}),
          64'd0);
    check("rst_ids_resps", 64'({AXI_bid, AXI_rid, AXI_bresp, AXI_rresp, AXI_rlast}), 64'd0);
    check("rst_rdata", 64'(AXI_rdata), 64'd0);
    check_counters("rst");
    rst = 1'b0;
    @(negedge clk);
    check("awready_before_first_edge", 64'(AXI_awready), 64'd0);
    @(posedge clk); #1;
    check("aw_ar_ready_after_release", 64'({AXI_awready, AXI_arready}), 64'h3);

    // INCR write/read of 4 words, read taken with rready held high
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'h11 * (i + 1);
      ws[i] = 4'hF;
    end
    do_write(32'h40, 4'd3, 2'b01, 3'b010, 6'h2A, -1);
    rr_manual = 1'b1;
    AXI_rready = 1'b1;
    hs_cyc.delete();
    do_read(32'h40, 4'd3, 2'b01, 3'b010, 6'h15);
    rr_manual = 1'b0;
    check("incr_read_beats", 64'(hs_cyc.size()), 64'd4);
    if (hs_cyc.size() == 4) check("incr_read_back_to_back", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
    check_counters("first_burst");

    // Fill the whole memory so later reads only see defined data
    for (int blk = 0; blk < 64; blk++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'hF;
      end
      do_write(32'(blk * 64), 4'd15, 2'b01, 3'b010, 6'(blk), -1);
    end

    // Partial strobes: 0x12345678 merged with 0xAABBCCDD on lanes 0 and 2 gives 0x12BB56DD
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    do_write(32'h100, 4'd0, 2'b01, 3'b010, 6'h01, -1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(32'h100, 4'd0, 2'b01, 3'b010, 6'h02, -1);
    do_read(32'h100, 4'd0, 2'b01, 3'b010, 6'h03);

    // WRAP read from the middle of a 4-word block: 0x48, 0x4C, 0x40, 0x44
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hA0 + 32'(i);
      ws[i] = 4'hF;
    end
    do_write(32'h40, 4'd3, 2'b01, 3'b010, 6'h04, -1);
    do_read(32'h48, 4'd3, 2'b10, 3'b010, 6'h05);

    // Error responses: bad awsize leaves memory untouched; early wlast consumes all beats
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
    do_write(32'h300, 4'd3, 2'b01, 3'b001, 6'h06, -1);
    do_read(32'h300, 4'd3, 2'b01, 3'b010, 6'h07);
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    do_write(32'h340, 4'd3, 2'b01, 3'b010, 6'h08, 2);
    do_read(32'h340, 4'd3, 2'b01, 3'b010, 6'h09);
    do_read(32'h340, 4'd1, 2'b01, 3'b100, 6'h0A);

    // rready pattern 1,0,0,1 on a 2-beat burst
    rr_manual = 1'b1;
    AXI_rready = 1'b0;
    push_read(32'h380, 4'd1, 2'b01, 3'b010, 6'h0B);
    send_ar(32'h380, 4'd1, 2'b01, 3'b010, 6'h0B);
    n = 0;
    while (!AXI_rvalid && n < 50) begin @(negedge clk); n++; end
    if (!AXI_rvalid) abort_timeout("r_valid");
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      AXI_rready = pat[i];
    end
    @(posedge clk); #1;
    AXI_rready = 1'b0;
    @(negedge clk);
    check("toggle_rvalid_after_2_beats", 64'(AXI_rvalid), 64'd0);
    check("toggle_beats_left", 64'(exp_r.size()), 64'd0);
    rr_manual = 1'b0;
    check_counters("toggle");

    // Reset in the middle of a write burst
    @(posedge clk); #1;
    send_aw(32'h200, 4'd3, 2'b01, 3'b010, 6'h0C);
    for (int i = 0; i < 2; i++) begin
      wd[i] = $urandom;
      mdl[128 + i] = wd[i];
      send_w(wd[i], 4'hF, 1'b0, 6'h0C);
    end
    @(negedge clk);
    check("pre_rst_wready", 64'(AXI_wready), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready_valid", 64'({AXI_awready, AXI_wready, AXI_bvalid}), 64'd0);
    wr_cnt = 0;
    rd_cnt = 0;
    check_counters("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready_low", 64'(AXI_awready), 64'd0);
    @(posedge clk); #1;
    check("post_rst_awready_high", 64'(AXI_awready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    do_read(32'h200, 4'd3, 2'b01, 3'b010, 6'h0D);

    // Random bursts
    for (int t = 0; t < 60; t++) begin
      n = int'($urandom_range(0, 9));
      rb = (n < 4) ? 2'b01 : (n < 6) ? 2'b00 : (n < 9) ? 2'b10 : 2'b11;
      if (rb == 2'b10) rlen = 4'((2 << $urandom_range(0, 3)) - 1);
      else rlen = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = $urandom;
          ws[i] = 4'($urandom);
        end
        early = (rlen != 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, rlen - 1)) : -1;
        do_write(a, rlen, rb, rs, 6'($urandom), early);
      end else begin
        do_read(a, rlen, rb, rs, 6'($urandom));
      end
    end
    check_counters("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi3_hp_slave.md
Name: axi3_hp_slave

Overview:
- AXI3 slave (responder) with an on-chip word memory. It is the far end of the 32-bit HP-port master protocol used by the stream-to-AXI DMA.
- Lets the DMA and its register space be exercised in loopback, with no PS DDR involved.
- Independent write channel (AW/W/B) and read channel (AR/R), each with one outstanding burst. Burst completion counters are exported for the register space.

Parameters:
- ADDR_W, 10, word-address bits; memory depth is 2^ADDR_W 32-bit words; byte address bits [ADDR_W+1:2] index it, upper bits are ignored.
- ID_W, 6, AXI ID width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- AXI_awaddr  in  32;  AXI_awburst  in  2;  AXI_awid  in  ID_W;  AXI_awlen  in  4;  AXI_awsize  in  3;  AXI_awvalid  in  1;  AXI_awready  out  1
- AXI_wdata  in  32;  AXI_wid  in  ID_W (ignored);  AXI_wstrb  in  4;  AXI_wlast  in  1;  AXI_wvalid  in  1;  AXI_wready  out  1
- AXI_bid  out  ID_W;  AXI_bresp  out  2;  AXI_bvalid  out  1;  AXI_bready  in  1
- AXI_araddr  in  32;  AXI_arburst  in  2;  AXI_arid  in  ID_W;  AXI_arlen  in  4;  AXI_arsize  in  3;  AXI_arvalid  in  1;  AXI_arready  out  1
- AXI_rdata  out  32;  AXI_rid  out  ID_W;  AXI_rresp  out  2;  AXI_rlast  out  1;  AXI_rvalid  out  1;  AXI_rready  in  1
- wr_bursts  out  32  completed write bursts (B handshakes), wraps 0xFFFFFFFF->0
- rd_bursts  out  32  completed read bursts (last R handshake), wraps

Behaviour:
- Reset: all ready/valid outputs 0; bid, rid, bresp, rresp, rdata, rlast 0; counters 0; both FSMs idle. Memory is not reset. awready/arready go to 1 on the first clock edge after reset deasserts.
- Reset mid-burst: the burst is abandoned immediately. Writes already performed stay in memory. No B or R response is issued.
- Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
- W_IDLE -> W_DATA on AW handshake. Latch id, word address, len, burst, and error flag err=(awsize!=3'b010).
- W_DATA, each W handshake: if !err, write mem[addr] byte lanes per wstrb. Then advance addr and beat count.
- Last beat is the one where beat==len; transition to W_RESP follows it. bvalid is asserted the cycle after the last W beat.
- wlast mismatch (asserted early, or missing on beat len) sets err. Beat counting alone ends the burst.
- W_RESP: bvalid held with bid, bresp=err?2'b10:2'b00 until bready. Then go to W_IDLE; awready is 1 the next cycle.
- Address advance: FIXED(00) holds addr; INCR(01) adds 1 word, modulo depth; WRAP(10) wraps within an aligned block of len+1 words. Reserved burst type 11 is treated as INCR and sets err.
- Read FSM states: R_IDLE (arready=1), R_DATA.
- R_IDLE -> R_DATA on AR handshake. In the same edge, rdata<=mem[araddr word], rid<=arid, rlast<=(arlen==0), rresp per the same err rule as writes. rvalid=1 the next cycle.
- R_DATA, each R handshake with !rlast: load rdata from the next address and update rlast, giving back-to-back beats (full throughput).
- rvalid/rdata/rlast are held stable while rready=0.
- Handshake with rlast=1: rvalid<=0, return to R_IDLE, increment rd_bursts.
- Read data is returned even when rresp=SLVERR.
- Simultaneous read load and write to the same word in one cycle: the read returns the pre-write data.
- Both FSMs run fully concurrently; neither channel ever stalls the other.

Optional Feature:
- Macro: AXI3_SLV_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11; reset to seed) advances every cycle.
- Defined: wready in W_DATA and arready in R_IDLE are ANDed with lfsr[0], producing pseudo-random backpressure for bench stress.
- Undefined: no LFSR and no gating; behaviour exactly as above.

Test Plan:
- INCR write, awaddr 0x40, awlen 3, data 0x11..0x44, wstrb 4'hF; then INCR read of the same burst -> bresp 00, bid echoed; R beats 0x11,0x22,0x33,0x44 back-to-back with rready=1, rlast only on beat 4; wr_bursts=1, rd_bursts=1.
- Write wstrb 4'b0101 data 0xAABBCCDD over a word holding 0x12345678, then read -> 0x12BB56DD.
- WRAP read, araddr 0x48, arlen 3 -> words 0x48,0x4C,0x40,0x44 returned in that order.
- awsize 3'b001 burst, or wlast asserted on beat 2 of a len 3 burst -> bresp 2'b10. For the awsize error, memory is unchanged; for the wlast error, all 4 beats are still consumed.
- Read with rready toggling 1,0,0,1 during a len 1 burst -> rdata stable while stalled; exactly 2 beats delivered.
- Assert rst in the middle of a write burst -> awready/wready/bvalid go to 0 immediately, no B response; awready=1 one cycle after release; counters read 0.
